// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// per-stage destination info carried by the shadow tracker, and FSM states.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } stage_info_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam stage_info_t BUBBLE = '0;

  // Youngest producer wins; a load still in EXE has no data yet, so fall
  // through to older stages (the load-use interlock covers that case).
  function automatic fwd_sel_e fwd_pick(logic [2:0] m, logic exe_ld);
    if (m[0] && !exe_ld) return FWD_EXE;
    if (m[1])            return FWD_MEM;
    if (m[2])            return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against the EXE/MEM/WB tracker entries.
// match_o[0] = EXE, [1] = MEM, [2] = WB.
module hazard_match
  import pipe_pkg::*;
(
  input  logic [4:0]  rs_i,
  input  logic        use_i,
  input  stage_info_t exe_i,
  input  stage_info_t mem_i,
  input  stage_info_t wb_i,
  output logic [2:0]  match_o
);

  logic src_live;
  logic unused_ld;

  assign src_live   = use_i & (rs_i != 5'd0);
  assign match_o[0] = src_live & exe_i.v & exe_i.we & (exe_i.rd == rs_i);
  assign match_o[1] = src_live & mem_i.v & mem_i.we & (mem_i.rd == rs_i);
  assign match_o[2] = src_live & wb_i.v  & wb_i.we  & (wb_i.rd  == rs_i);

  // Load flags matter only to the caller's priority logic.
  assign unused_ld = ^{exe_i.ld, mem_i.ld, wb_i.ld};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: forwarding, load-use
// interlock, branch flush, multi-cycle stall. Optional HAZARD_PERF_CNT_EN adds
// saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_ref_we,
  input  logic              id_dram_re,
  input  logic              id_long_op,
  input  logic              exe_br_taken,
  output logic              id_ready_go,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              exe_hold,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  stage_info_t      exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       m1, m2;
  logic             busy, load_use;

  hazard_match u_hm1 (
    .rs_i(id_rs1), .use_i(id_use_rs1),
    .exe_i(exe_q), .mem_i(mem_q), .wb_i(wb_q), .match_o(m1)
  );

  hazard_match u_hm2 (
    .rs_i(id_rs2), .use_i(id_use_rs2),
    .exe_i(exe_q), .mem_i(mem_q), .wb_i(wb_q), .match_o(m2)
  );

  assign busy        = (state_q == ST_BUSY);
  assign load_use    = exe_q.ld & (m1[0] | m2[0]);
  assign id_ready_go = id_valid & ~load_use & ~exe_br_taken & ~busy;
  // A long op is never a branch, so a taken flag seen while busy is stale.
  assign if_id_flush = exe_br_taken & ~busy;
  assign if_id_stall = busy | (load_use & ~exe_br_taken);
  assign exe_hold    = busy;
  assign fwd_sel1    = fwd_pick(m1, exe_q.ld);
  assign fwd_sel2    = fwd_pick(m2, exe_q.ld);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (id_ready_go && id_long_op) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(LONG_LAT - 1);
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_d = mem_q;
    if (busy) begin
      exe_d = exe_q;
      mem_d = BUBBLE;
    end else begin
      mem_d = exe_q;
      exe_d = id_ready_go ? '{v: 1'b1, rd: id_rd, we: id_ref_we, ld: id_dram_re}
                          : BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exe_q   <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (if_id_stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (if_id_flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`else
  localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, checked against an instruction-level model of the pipeline.
module tb_pipe_hazard_ctrl;

  localparam int LONG_LAT = 4;

  typedef struct {
    bit       rst, v, u1, u2, we, ld, lng, br;
    bit [4:0] rs1, rs2, rd;
  } stim_t;

  typedef struct {
    bit        rg, st, fl, hd;
    bit [1:0]  s1, s2;
    bit [31:0] pst, pfl;
  } exp_t;

  typedef struct { bit v; bit [4:0] rd; bit we, ld; } ins_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic       id_ref_we = 0, id_dram_re = 0, id_long_op = 0, exe_br_taken = 0;
  logic       id_ready_go, if_id_stall, if_id_flush, exe_hold;
  logic [1:0] fwd_sel1, fwd_sel2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.LONG_LAT(LONG_LAT), .CNT_W(3), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_ref_we(id_ref_we), .id_dram_re(id_dram_re), .id_long_op(id_long_op),
    .exe_br_taken(exe_br_taken), .id_ready_go(id_ready_go),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .exe_hold(exe_hold),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: pl[0]=EXE, pl[1]=MEM, pl[2]=WB; hold_left = remaining
  // cycles the multi-cycle op stays frozen in EXE.
  ins_t      pl[3];
  int        hold_left = 0;
  bit [31:0] m_pst = 0, m_pfl = 0;
  exp_t      sb[$];
  int        vectors = 0, miscompares = 0;

  function automatic void src_eval(input bit [4:0] rs, input bit use_it,
                                   output bit [1:0] sel, output bit lu);
    sel = 0; lu = 0;
    if (use_it && rs != 0)
      for (int k = 2; k >= 0; k--)
        if (pl[k].v && pl[k].we && pl[k].rd == rs) begin
          if (k == 0 && pl[k].ld) lu = 1;
          else sel = 2'(k + 1);
        end
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit lu1, lu2, lu, busy;
    @(posedge clk); #1;
    rst = s.rst; id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_rd = s.rd; id_ref_we = s.we;
    id_dram_re = s.ld; id_long_op = s.lng; exe_br_taken = s.br;
    busy = hold_left > 0;
    src_eval(s.rs1, s.u1, e.s1, lu1);
    src_eval(s.rs2, s.u2, e.s2, lu2);
    lu   = lu1 | lu2;
    e.hd = busy;
    e.rg = s.v && !lu && !s.br && !busy;
    e.fl = s.br && !busy;
    e.st = busy || (lu && !s.br);
    e.pst = m_pst; e.pfl = m_pfl;
    sb.push_back(e);
    // state after the coming edge
    if (s.rst) begin
      foreach (pl[k]) pl[k] = '{0, 0, 0, 0};
      hold_left = 0; m_pst = 0; m_pfl = 0;
    end else begin
      if (e.st && m_pst != '1) m_pst++;
      if (e.fl && m_pfl != '1) m_pfl++;
      pl[2] = pl[1];
      if (busy) begin
        pl[1] = '{0, 0, 0, 0};
        hold_left--;
      end else begin
        pl[1] = pl[0];
        pl[0] = e.rg ? ins_t'{1, s.rd, s.we, s.ld} : ins_t'{0, 0, 0, 0};
        if (e.rg && s.lng) hold_left = LONG_LAT - 1;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if ({id_ready_go, if_id_stall, if_id_flush, exe_hold, fwd_sel1, fwd_sel2} !==
          {e.rg, e.st, e.fl, e.hd, e.s1, e.s2}) begin
        miscompares++;
        $display("FAIL outputs @%0t: got rg=%b st=%b fl=%b hd=%b s1=%0d s2=%0d, want rg=%b st=%b fl=%b hd=%b s1=%0d s2=%0d",
                 $time, id_ready_go, if_id_stall, if_id_flush, exe_hold, fwd_sel1, fwd_sel2,
                 e.rg, e.st, e.fl, e.hd, e.s1, e.s2);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (perf_stall_cnt !== e.pst || perf_flush_cnt !== e.pfl) begin
        miscompares++;
        $display("FAIL perf @%0t: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                 $time, perf_stall_cnt, perf_flush_cnt, e.pst, e.pfl);
      end
`endif
    end
  end

  function automatic stim_t idle(input bit r);
    stim_t s = '{default: 0};
    s.rst = r;
    return s;
  endfunction

  // valid instr: rd, rs1, rs2, uses, we, ld, long
  function automatic stim_t ins(input int rd, input int r1, input int r2, input bit u1,
                                input bit u2, input bit we, input bit ld, input bit lng);
    stim_t s = '{default: 0};
    s.v = 1; s.rd = 5'(rd); s.rs1 = 5'(r1); s.rs2 = 5'(r2);
    s.u1 = u1; s.u2 = u2; s.we = we; s.ld = ld; s.lng = lng;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s = '{default: 0};
    if ($urandom_range(63) == 0) begin
      s.rst = 1;
      return s;
    end
    s.v  = ($urandom_range(3) != 0);
    s.br = ($urandom_range(7) == 0);
    if (s.v) begin
      s.rs1 = 5'($urandom_range(3)); s.rs2 = 5'($urandom_range(3));
      s.rd  = 5'($urandom_range(3));
      s.u1  = 1'($urandom); s.u2 = 1'($urandom); s.we = ($urandom_range(4) != 0);
      s.ld  = s.we && ($urandom_range(3) == 0);
      s.lng = !s.ld && ($urandom_range(7) == 0);
    end
    return s;
  endfunction

  initial begin
    stim_t s;
    foreach (pl[k]) pl[k] = '{0, 0, 0, 0};
    repeat (2) apply(idle(1));                 // reset state
    apply(idle(0));
    // add r4,r1,r2 ; sub r5,r4,r3 -> EXE forward
    apply(ins(4, 1, 2, 1, 1, 1, 0, 0));
    apply(ins(5, 4, 3, 1, 1, 1, 0, 0));
    apply(idle(0));
    // ld r6 ; add r7,r6,r6 -> one stall, then MEM forward
    apply(ins(6, 0, 0, 0, 0, 1, 1, 0));
    apply(ins(7, 6, 6, 1, 1, 1, 0, 0));
    apply(ins(7, 6, 6, 1, 1, 1, 0, 0));
    apply(idle(0));
    // writer of r0 then reader of r0
    apply(ins(0, 1, 1, 1, 0, 1, 0, 0));
    apply(ins(8, 0, 0, 1, 1, 1, 0, 0));
    apply(idle(0));
    // branch taken against a load-use victim
    apply(ins(6, 0, 0, 0, 0, 1, 1, 0));
    s = ins(7, 6, 6, 1, 1, 1, 0, 0); s.br = 1;
    apply(s);
    apply(idle(0)); apply(idle(0));
    // full long op with dependent consumer, then back-to-back long ops
    apply(ins(9, 1, 2, 1, 1, 1, 0, 1));
    repeat (4) apply(ins(10, 9, 0, 1, 0, 1, 0, 0));
    apply(ins(11, 1, 2, 1, 1, 1, 0, 1));
    apply(ins(12, 1, 2, 1, 1, 1, 0, 1));
    s = ins(13, 12, 0, 1, 0, 1, 0, 0); s.br = 1;
    repeat (2) apply(s);                       // branch ignored while busy
    repeat (3) apply(ins(13, 12, 0, 1, 0, 1, 0, 0));
    // long op interrupted by reset in its second busy cycle
    apply(ins(9, 1, 2, 1, 1, 1, 0, 1));
    apply(ins(10, 9, 0, 1, 0, 1, 0, 0));
    apply(idle(1));
    repeat (2) apply(idle(0));
    // random traffic
    repeat (3000) apply(rnd());
    apply(idle(0));
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EXE/MEM/WB).
- Drives the ID/EXE register's ready_go; de-asserting it loads a bubble.
- Generates src1/src2 forwarding selects, load-use interlock, branch flush and multi-cycle-op stall.
- Keeps its own shadow tracker of destination-register info for the EXE, MEM and WB stages.

Parameters:
LONG_LAT, 4, total EXE-stage cycles of a multi-cycle (mul/div) op, ≥2
CNT_W, 3, width of the busy counter, ≥ clog2(LONG_LAT)
PERF_W, 32, width of the performance counters (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  5  destination index
id_ref_we  in  1  instruction writes the register file
id_dram_re  in  1  instruction is a load
id_long_op  in  1  instruction is multi-cycle
exe_br_taken  in  1  branch/jump resolved taken in EXE
id_ready_go  out  1  ID may issue to EXE; 0 loads a bubble into ID/EXE
if_id_stall  out  1  hold PC and IF/ID
if_id_flush  out  1  squash IF/ID contents
exe_hold  out  1  hold EXE/MEM-side registers (multi-cycle op)
fwd_sel1  out  2  0 = RF, 1 = EXE, 2 = MEM, 3 = WB
fwd_sel2  out  2  same encoding as fwd_sel1

Behaviour:
Reset values (outputs are functions of state and inputs; values hold while rst = 1, inputs idle):
- All tracker entries invalid; FSM in IDLE.
- id_ready_go = 0, stalls and flush = 0, fwd_sel* = 0.

Tracker:
- Three entries {v, rd, we, ld} for EXE, MEM and WB.
- Each cycle, when not holding:
  - WB ← MEM; MEM ← EXE.
  - EXE ← ID info if (id_valid & id_ready_go), else bubble (v = 0).
- During exe_hold: EXE holds, MEM ← bubble, WB ← MEM.

Hazard match: stage S matches rsN iff S.v & S.we & S.rd == rsN & rsN != 0 & id_use_rsN.

Forwarding (combinational):
- Priority EXE (non-load only) > MEM > WB > RF.
- A load in MEM forwards (sel = 2); r0 always selects RF.

Load-use:
- Triggered when EXE.ld matches rs1 or rs2.
- id_ready_go = 0 and if_id_stall = 1 for exactly one cycle; next cycle the load is in MEM and forwards.

Branch:
- exe_br_taken → if_id_flush = 1, id_ready_go = 0 (wrong-path ID becomes bubble), if_id_stall = 0.
- Flush overrides a simultaneous load-use stall.

FSM, states IDLE and BUSY:
- IDLE → BUSY when a long op issues (id_valid & id_long_op & id_ready_go); cnt ← LONG_LAT-1.
- In BUSY:
  - exe_hold = 1, id_ready_go = 0, if_id_stall = 1; cnt decrements each cycle.
  - BUSY → IDLE when cnt == 1, giving LONG_LAT total EXE cycles.
  - exe_br_taken is ignored, since a long op is never a branch.
- Back-to-back long ops: the second issues on the first IDLE cycle.

id_ready_go = id_valid & ~load_use & ~exe_br_taken & (state == IDLE).

Reset mid-operation: a sync rst in BUSY returns to IDLE and clears the tracker in the same edge.

Optional Feature:
Macro: HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs perf_stall_cnt [PERF_W] and perf_flush_cnt [PERF_W], both reset to 0.
  - perf_stall_cnt increments on every cycle with if_id_stall = 1.
  - perf_flush_cnt increments on every cycle with if_id_flush = 1.
  - Both saturate at all-ones.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
Shared package pipe_pkg holds:
- Forwarding encodings FWD_RF / FWD_EXE / FWD_MEM / FWD_WB.
- The stage-info struct/typedef {v, rd, we, ld}.
- The FSM state encoding.

Sub-module: hazard_match (combinational comparator of one source against the three tracker entries, returning the match vector), instantiated twice.

Test Plan:
1. add r4,r1,r2 then sub r5,r4,r3 back-to-back → fwd_sel1 = 1 in the sub's ID cycle, no stall.
2. ld.w r6 then add r7,r6,r6 → one cycle with id_ready_go = 0 and if_id_stall = 1; next cycle fwd_sel1 = fwd_sel2 = 2.
3. Producer of r0 followed by a reader of r0 → fwd_sel = 0 and no stall.
4. exe_br_taken = 1 while ID holds a load-use victim → if_id_flush = 1, if_id_stall = 0, bubble issued.
5. Long op with LONG_LAT = 4 → exe_hold = 1 for 3 cycles, issue resumes on the 4th; rst asserted in cycle 2 → IDLE next edge, all outputs at reset values.
6. With HAZARD_PERF_CNT_EN defined, run scenarios 2 and 4 → perf_stall_cnt = 1, perf_flush_cnt = 1.
